uart_rx_frame_manager: RTL
==========================

# uart_rx_frame_manager

Controller sitting between the UART receiver and the system side. It owns the receiver's runtime configuration (prescale, parity enable) and applies changes only between frames. It buffers received bytes in a small FIFO with a valid/ready output, and keeps saturating error and overrun counters.

## Interface
Parameters:
- DATA_WIDTH, 8, received byte width
- FIFO_DEPTH, 4, byte buffer depth; power of two, ≥2
- CNT_WIDTH, 8, width of each error counter
- RESET_PRESCALE, 8, prescale value loaded at reset; must be 8, 16 or 32

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cfg_valid  in  1  new configuration offered
- cfg_prescale  in  6  requested oversampling ratio
- cfg_parity_enable  in  1  requested parity enable
- cfg_ready  out  1  config handshake ready
- cfg_done  out  1  one-cycle pulse when the new config is applied
- cfg_error  out  1  one-cycle pulse when an illegal prescale is rejected
- rx_busy  in  1  receiver FSM not in IDLE
- rx_hold  out  1  request to the top level to block new start-bit detection
- rx_prescale  out  6  registered prescale driving the receiver
- rx_parity_enable  out  1  registered parity enable driving the receiver
- rx_data  in  DATA_WIDTH  deserialized byte
- rx_data_valid  in  1  one-cycle pulse, byte accepted by the receiver
- rx_parity_error  in  1  one-cycle pulse
- rx_stop_error  in  1  one-cycle pulse
- out_data  out  DATA_WIDTH  FIFO head
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer pops when valid & ready
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- clear_counts  in  1  synchronous clear of all counters
- parity_err_count, stop_err_count, overrun_count  out  CNT_WIDTH each

## Operation
- **Reset values:**
  - rx_prescale = RESET_PRESCALE, rx_parity_enable = 0.
  - cfg_ready = 1; cfg_done, cfg_error, rx_hold = 0.
  - FIFO empty, so out_valid = 0, fifo_level = 0, out_data = 0.
  - All counters 0.
- **Config FSM states:** CFG_IDLE, CFG_WAIT, CFG_APPLY.
  - CFG_IDLE: cfg_ready = 1.
    - On cfg_valid with prescale in {8, 16, 32}: capture pending values and go to CFG_WAIT.
    - On cfg_valid with an illegal prescale: pulse cfg_error next cycle, stay in CFG_IDLE, leave the config unchanged.
  - CFG_WAIT: cfg_ready = 0, rx_hold = 1.
    - When rx_busy = 0: load rx_prescale and rx_parity_enable from the pending values on that edge, go to CFG_APPLY.
  - CFG_APPLY: lasts one cycle. cfg_done = 1, rx_hold = 1, then return to CFG_IDLE.
  - A frame already in progress is never disturbed; CFG_WAIT persists as long as rx_busy = 1.
- **FIFO:**
  - Push on rx_data_valid when not full. Pop on out_valid & out_ready.
  - Push when full is dropped and overrun_count increments.
  - Full with a simultaneous pop: the push is accepted, level unchanged, no overrun.
  - Empty with a simultaneous push: only the push takes effect (no pop, since out_valid = 0).
  - Pointers wrap modulo FIFO_DEPTH.
- **Counters:**
  - Increment by 1 per error pulse; saturate at all-ones.
  - clear_counts has priority over a same-cycle increment (that event is lost).
- **Reset mid-operation:** FIFO contents are discarded, a pending config is lost, and the FSM returns to CFG_IDLE.

## Timing
- Byte pulse at edge N: out_valid = 1 and out_data valid after edge N (fall-through, 1-cycle latency). Pop takes effect at the same edge.
- Config accepted at edge N with rx_busy = 0:
  - state is CFG_WAIT after N;
  - rx_prescale updates at N+1;
  - cfg_done is high for the cycle after N+1.
- If rx_busy stays high for K cycles after acceptance, the config update is delayed by K cycles.
- cfg_error is high for exactly the cycle after the rejecting edge.
- fifo_level and the counters are registered and reflect events of the previous edge.

## Structure
- Package uart_rx_ctrl_pkg contains:
  - config state encoding (CFG_IDLE = 2'b00, CFG_WAIT = 2'b01, CFG_APPLY = 2'b10);
  - legal prescale constants 8, 16, 32.
- Sub-module uart_rx_byte_fifo: synchronous FIFO with push/pop, full/empty and level. Counters and the config FSM stay in the top.

## Test plan
- **Reset defaults:** reset low, then release → rx_prescale = 8, rx_parity_enable = 0, cfg_ready = 1, out_valid = 0, all counts 0.
- **Config while idle:** cfg_valid with prescale = 16, parity = 1, rx_busy = 0 → rx_prescale = 16 one edge after acceptance, then a single-cycle cfg_done.
- **Config mid-frame:** rx_busy high for 20 cycles → rx_prescale unchanged and rx_hold = 1 throughout; update takes effect on the first edge with rx_busy = 0.
- **Illegal prescale:** cfg_prescale = 12 → cfg_error one cycle, rx_prescale unchanged.
- **FIFO overrun:** push 0x11, 0x22, 0x33, 0x44, 0x55 with out_ready = 0 → level = 4, overrun_count = 1; popping yields 0x11…0x44 in order. Full with simultaneous push and pop: level stays 4 and no overrun.
- **Counter saturation and clear:** 300 rx_parity_error pulses → parity_err_count = 255. clear_counts asserted together with a stop-error pulse → stop_err_count = 0.

Source files
------------

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive frame manager: config FSM encoding
// and the set of oversampling ratios the receiver supports.
package uart_rx_ctrl_pkg;

   typedef enum logic [1:0] {
      CFG_IDLE  = 2'b00,
      CFG_WAIT  = 2'b01,
      CFG_APPLY = 2'b10
   } cfg_state_t;

   localparam logic [5:0] PRESCALE_8  = 6'd8;
   localparam logic [5:0] PRESCALE_16 = 6'd16;
   localparam logic [5:0] PRESCALE_32 = 6'd32;

   function automatic logic prescale_legal(input logic [5:0] prescale);
      return (prescale == PRESCALE_8) || (prescale == PRESCALE_16) ||
             (prescale == PRESCALE_32);
   endfunction

endpackage

// File: rtl/uart_rx_byte_fifo.sv
// Small synchronous byte FIFO with fall-through head, occupancy level and
// full/empty flags. The caller only pushes when there is room (or a pop frees it).
module uart_rx_byte_fifo
   import uart_rx_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [DATA_WIDTH-1:0]    push_data,
   input  logic                     pop,
   output logic [DATA_WIDTH-1:0]    pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;

   assign full     = (level == LW'(DEPTH));
   assign empty    = (level == '0);
   assign pop_data = empty ? '0 : mem[rd_ptr];

   // Storage carries no reset; the head is masked to zero while empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer width matches the power-of-two depth, so increments wrap naturally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_frame_manager.sv
// Owns the UART receiver's runtime configuration (swapped only between frames),
// buffers received bytes and keeps saturating error/overrun counters.
module uart_rx_frame_manager
   import uart_rx_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int FIFO_DEPTH     = 4,
   parameter int CNT_WIDTH      = 8,
   parameter int RESET_PRESCALE = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         cfg_valid,
   input  logic [5:0]                   cfg_prescale,
   input  logic                         cfg_parity_enable,
   output logic                         cfg_ready,
   output logic                         cfg_done,
   output logic                         cfg_error,
   input  logic                         rx_busy,
   output logic                         rx_hold,
   output logic [5:0]                   rx_prescale,
   output logic                         rx_parity_enable,
   input  logic [DATA_WIDTH-1:0]        rx_data,
   input  logic                         rx_data_valid,
   input  logic                         rx_parity_error,
   input  logic                         rx_stop_error,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
   input  logic                         clear_counts,
   output logic [CNT_WIDTH-1:0]         parity_err_count,
   output logic [CNT_WIDTH-1:0]         stop_err_count,
   output logic [CNT_WIDTH-1:0]         overrun_count,
   output logic [1:0]                   cfg_state
);

   // Handshakes: a config transfer happens on an edge where cfg_valid & cfg_ready;
   // a byte leaves the FIFO on an edge where out_valid & out_ready. Valid never
   // waits on ready, and the producer holds its payload until the transfer edge.

   cfg_state_t state, state_next;
   logic       capture, apply, reject;
   logic [5:0] pending_prescale;
   logic       pending_parity;

   logic fifo_full, fifo_empty, fifo_push, fifo_pop, overrun_event;

   assign cfg_state = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= CFG_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      capture    = 1'b0;
      apply      = 1'b0;
      reject     = 1'b0;
      cfg_ready  = 1'b0;
      cfg_done   = 1'b0;
      rx_hold    = 1'b0;
      case (state)
         CFG_IDLE: begin
            cfg_ready = 1'b1;
            if (cfg_valid) begin
               if (prescale_legal(cfg_prescale)) begin
                  capture    = 1'b1;
                  state_next = CFG_WAIT;
               end else begin
                  reject = 1'b1;
               end
            end
         end
         CFG_WAIT: begin
            rx_hold = 1'b1;
            // A frame in flight keeps its timing; swap only once the receiver idles.
            if (!rx_busy) begin
               apply      = 1'b1;
               state_next = CFG_APPLY;
            end
         end
         CFG_APPLY: begin
            rx_hold    = 1'b1;
            cfg_done   = 1'b1;
            state_next = CFG_IDLE;
         end
         default: state_next = CFG_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending_prescale <= 6'(RESET_PRESCALE);
         pending_parity   <= 1'b0;
         rx_prescale      <= 6'(RESET_PRESCALE);
         rx_parity_enable <= 1'b0;
         cfg_error        <= 1'b0;
      end else begin
         cfg_error <= reject;
         if (capture) begin
            pending_prescale <= cfg_prescale;
            pending_parity   <= cfg_parity_enable;
         end
         if (apply) begin
            rx_prescale      <= pending_prescale;
            rx_parity_enable <= pending_parity;
         end
      end
   end

   // A full FIFO still accepts a byte when the head leaves on the same edge.
   assign fifo_pop      = out_valid && out_ready;
   assign fifo_push     = rx_data_valid && (!fifo_full || fifo_pop);
   assign overrun_event = rx_data_valid && fifo_full && !fifo_pop;
   assign out_valid     = !fifo_empty;

   uart_rx_byte_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (rx_data),
      .pop       (fifo_pop),
      .pop_data  (out_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   // Saturating counters; a clear on the same edge wins over the event.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         parity_err_count <= '0;
         stop_err_count   <= '0;
         overrun_count    <= '0;
      end else if (clear_counts) begin
         parity_err_count <= '0;
         stop_err_count   <= '0;
         overrun_count    <= '0;
      end else begin
         if (rx_parity_error && (parity_err_count != '1))
            parity_err_count <= parity_err_count + 1'b1;
         if (rx_stop_error && (stop_err_count != '1))
            stop_err_count <= stop_err_count + 1'b1;
         if (overrun_event && (overrun_count != '1))
            overrun_count <= overrun_count + 1'b1;
      end
   end

endmodule
